// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: access-size encodings (also used by the hazard unit)
// and the data-memory port FSM state encoding.
package pipeline_pkg;

  localparam logic [1:0] MASK_BYTE    = 2'd0;
  localparam logic [1:0] MASK_HALF    = 2'd1;
  localparam logic [1:0] MASK_WORD    = 2'd2;
  localparam logic [1:0] MASK_ILLEGAL = 2'd3;

  typedef enum logic {
    DMEM_IDLE      = 1'b0,
    DMEM_RMW_MERGE = 1'b1
  } dmem_state_e;

  // True when the byte offset is not aligned to the access size.
  function automatic logic mask_misaligned(input logic [1:0] mask, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    if (mask == MASK_HALF) mis = lane[0];
    else if (mask == MASK_WORD) mis = (lane != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: extract/extend a loaded field, and merge a
// byte/half store into the word read back from the RAM.
module dmem_lane_unit
  import pipeline_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_lane,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  output logic [31:0] ld_data,
  input  logic [31:0] st_old_word,
  input  logic [1:0]  st_lane,
  input  logic [1:0]  st_size,
  input  logic [15:0] st_wdata,
  output logic [31:0] st_word
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Half accesses select on lane[1] only, so a misaligned half (when allowed) lands on its half.
  assign ld_byte = ld_word[{ld_lane, 3'b000} +: 8];
  assign ld_half = ld_word[{ld_lane[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = ld_word;
    case (ld_size)
      MASK_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      MASK_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default:   ld_data = ld_word;
    endcase
  end

  always_comb begin
    st_word = st_old_word;
    case (st_size)
      MASK_BYTE: st_word[{st_lane, 3'b000} +: 8]     = st_wdata[7:0];
      MASK_HALF: st_word[{st_lane[1], 4'b0000} +: 16] = st_wdata;
      default:   st_word = st_old_word;
    endcase
  end

endmodule

// File: rtl/dmem_rmw_port.sv
// MEM-stage data-memory port: single-access word loads/stores, pipelined
// sub-word loads, and a two-cycle read-modify-write for byte/half stores.
module dmem_rmw_port
  import pipeline_pkg::*;
#(
  parameter int AW              = 12,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic          req_read,
  input  logic          req_write,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [1:0]    req_maskMode,
  input  logic          req_unsigned,
  input  logic          flush,
  output logic          busy,
  output logic          rdata_valid,
  output logic [31:0]   rdata,
  output logic          err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output dmem_state_e   state_dbg
);

  // Handshake: a request is taken when req_valid=1, flush=0 and the FSM is idle.
  // busy=1 means the port is occupied next cycle; the requester holds its
  // request until busy drops, and nothing is accepted during RMW_MERGE.

  dmem_state_e state_q, state_d;

  logic          req_live;
  logic          req_illegal;
  logic          req_misaligned;
  logic          req_bad;
  logic          acc_ok;
  logic          acc_load;
  logic          acc_wstore;
  logic          acc_sstore;
  logic          acc_any;
  logic [AW-1:0] req_waddr;

  logic [AW-1:0] rmw_addr_q;
  logic [1:0]    rmw_lane_q;
  logic [1:0]    rmw_size_q;
  logic [15:0]   rmw_wdata_q;

  logic          ld_valid_q;
  logic [1:0]    ld_lane_q;
  logic [1:0]    ld_size_q;
  logic          ld_unsigned_q;
  logic          err_q;
  logic [31:0]   rdata_hold_q;

  logic [31:0]   ld_data;
  logic [31:0]   merged_word;
  logic          addr_hi_unused;

  assign req_waddr      = req_addr[AW+1:2];
  assign addr_hi_unused = ^req_addr[31:AW+2];

  // Gating with rst_n keeps every RAM strobe low while reset is held.
  assign req_live       = rst_n & req_valid & ~flush & (state_q == DMEM_IDLE);
  // Unknown size and read+write are always rejected; only alignment is optional.
  assign req_illegal    = (req_maskMode == MASK_ILLEGAL) | (req_read & req_write);
  assign req_misaligned = mask_misaligned(req_maskMode, req_addr[1:0]);
  assign req_bad        = req_illegal | (ERR_ON_MISALIGN && req_misaligned);
  assign acc_ok         = req_live & ~req_bad;
  assign acc_load       = acc_ok & req_read;
  assign acc_wstore     = acc_ok & req_write & (req_maskMode == MASK_WORD);
  assign acc_sstore     = acc_ok & req_write & (req_maskMode != MASK_WORD);
  assign acc_any        = acc_load | acc_wstore | acc_sstore;

  dmem_lane_unit u_lane (
    .ld_word     (mem_rdata),
    .ld_lane     (ld_lane_q),
    .ld_size     (ld_size_q),
    .ld_unsigned (ld_unsigned_q),
    .ld_data     (ld_data),
    .st_old_word (mem_rdata),
    .st_lane     (rmw_lane_q),
    .st_size     (rmw_size_q),
    .st_wdata    (rmw_wdata_q),
    .st_word     (merged_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DMEM_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DMEM_IDLE:      if (acc_sstore) state_d = DMEM_RMW_MERGE;
      DMEM_RMW_MERGE: state_d = DMEM_IDLE;
      default:        state_d = DMEM_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      DMEM_IDLE: begin
        busy   = acc_sstore;
        mem_en = acc_any;
        mem_we = acc_wstore;
        if (acc_any)    mem_addr  = req_waddr;
        if (acc_wstore) mem_wdata = req_wdata;
      end
      DMEM_RMW_MERGE: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = rmw_addr_q;
        mem_wdata = merged_word;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q         <= 1'b0;
      ld_valid_q    <= 1'b0;
      ld_lane_q     <= 2'b00;
      ld_size_q     <= MASK_BYTE;
      ld_unsigned_q <= 1'b0;
      rmw_addr_q    <= '0;
      rmw_lane_q    <= 2'b00;
      rmw_size_q    <= MASK_BYTE;
      rmw_wdata_q   <= 16'h0000;
      rdata_hold_q  <= 32'h0000_0000;
    end else begin
      err_q      <= req_live & req_bad;
      ld_valid_q <= acc_load;
      if (acc_load) begin
        ld_lane_q     <= req_addr[1:0];
        ld_size_q     <= req_maskMode;
        ld_unsigned_q <= req_unsigned;
      end
      if (acc_sstore) begin
        rmw_addr_q  <= req_waddr;
        rmw_lane_q  <= req_addr[1:0];
        rmw_size_q  <= req_maskMode;
        rmw_wdata_q <= req_wdata[15:0];
      end
      if (ld_valid_q) rdata_hold_q <= ld_data;
    end
  end

  // Load data comes straight off the RAM in the response cycle, then is held.
  assign rdata       = ld_valid_q ? ld_data : rdata_hold_q;
  assign rdata_valid = ld_valid_q;
  assign err         = err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_dmem_rmw_port.sv
// Bench for dmem_rmw_port: reset checks, a vector table of single loads and
// illegal requests, hand-written multi-cycle sequences, and a randomized run.
module tb_dmem_rmw_port;
  import pipeline_pkg::*;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_read, req_write, req_unsigned, flush;
  logic [31:0]   req_addr, req_wdata;
  logic [1:0]    req_maskMode;
  logic          busy, rdata_valid, err, mem_en, mem_we;
  logic [31:0]   rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  dmem_state_e   state_dbg;

  // ---------------- clock / reset / RAM ----------------
  always #5 clk = ~clk;

  logic [31:0]   ram [0:(1<<AW)-1];
  logic          pk_en = 1'b0;
  logic [AW-1:0] pk_addr = '0;
  logic [31:0]   pk_data = '0;

  always @(posedge clk) begin
    if (pk_en) ram[pk_addr] <= pk_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  dmem_rmw_port #(.AW(AW), .ERR_ON_MISALIGN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_maskMode(req_maskMode), .req_unsigned(req_unsigned), .flush(flush),
    .busy(busy), .rdata_valid(rdata_valid), .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] m, input logic u, input logic f);
    req_valid = v; req_read = rd; req_write = wr; req_addr = a;
    req_wdata = wd; req_maskMode = m; req_unsigned = u; flush = f;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, MASK_WORD, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    pk_en = 1'b1; pk_addr = a[AW-1:0]; pk_data = d;
    next_cycle();
    pk_en = 1'b0;
  endtask

  // ---------------- reference model (architectural semantics) ----------------
  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] m, input logic u);
    int unsigned sh;
    logic [31:0] v;
    if (m == MASK_BYTE) begin
      sh = 32'(off) * 8;
      v  = (word >> sh) & 32'hFF;
      if (!u && v >= 32'd128) v = v - 32'd256;
    end else if (m == MASK_HALF) begin
      sh = (32'(off) / 2) * 16;
      v  = (word >> sh) & 32'hFFFF;
      if (!u && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] m, input logic [31:0] d);
    int unsigned sh;
    logic [31:0] msk;
    msk = (m == MASK_BYTE) ? 32'hFF : 32'hFFFF;
    sh  = (m == MASK_BYTE) ? 32'(off) * 8 : (32'(off) / 2) * 16;
    return (word & ~(msk << sh)) | ((d & msk) << sh);
  endfunction

  function automatic logic is_illegal(input logic rd, input logic wr, input logic [31:0] a,
                                      input logic [1:0] m);
    return (m == 2'd3) || (rd && wr) || (m == MASK_HALF && a[0]) ||
           (m == MASK_WORD && a[1:0] != 2'b00);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [1:0]  mask;
    logic        uns, fl;
    logic        exp_en, exp_err, exp_rv;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [1:0] m, input logic u,
                              input logic f, input logic en, input logic er,
                              input logic rv, input logic [31:0] rdv);
    vec_t t;
    t.rd = rd; t.wr = wr; t.addr = a; t.wdata = wd; t.mask = m; t.uns = u; t.fl = f;
    t.exp_en = en; t.exp_err = er; t.exp_rv = rv; t.exp_rdata = rdv;
    return t;
  endfunction

  // random-phase model state
  logic [31:0]   exp_mem [0:7];
  logic          mg, p_err, p_rv, n_err, n_rv;
  logic [31:0]   p_rdata, n_rdata, last_rdata, mg_word;
  logic [AW-1:0] mg_addr, w;
  logic          e_busy, e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_wd;
  logic          r_v, r_rd, r_wr, r_u, r_f;
  logic [31:0]   r_a, r_wd;
  logic [1:0]    r_m;

  initial begin
    idle();
    // ---------------- reset ----------------
    repeat (2) @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, MASK_WORD, 1'b0, 1'b0);
    #1;
    chk("rst busy", busy, 0);
    chk("rst rdata_valid", rdata_valid, 0);
    chk("rst err", err, 0);
    chk("rst mem_en", mem_en, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst rdata", rdata, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst state", 32'(state_dbg), 32'(DMEM_IDLE));
    idle();
    rst_n = 1'b1;
    next_cycle();

    poke(0, 32'hDEAD_BEEF);
    poke(1, 32'h1122_3344);
    poke(2, 32'h8000_7FFF);
    poke(3, 32'hCAFE_F00D);

    // ---------------- table-driven single requests ----------------
    vecs.push_back(mk(1,0,32'h4,0,MASK_BYTE,0,0, 1,0,1,32'h0000_0044));
    vecs.push_back(mk(1,0,32'h0,0,MASK_BYTE,0,0, 1,0,1,32'hFFFF_FFEF));
    vecs.push_back(mk(1,0,32'h3,0,MASK_BYTE,1,0, 1,0,1,32'h0000_00DE));
    vecs.push_back(mk(1,0,32'hD,0,MASK_BYTE,0,0, 1,0,1,32'hFFFF_FFF0));
    vecs.push_back(mk(1,0,32'hA,0,MASK_HALF,0,0, 1,0,1,32'hFFFF_8000));
    vecs.push_back(mk(1,0,32'hA,0,MASK_HALF,1,0, 1,0,1,32'h0000_8000));
    vecs.push_back(mk(1,0,32'h8,0,MASK_HALF,0,0, 1,0,1,32'h0000_7FFF));
    vecs.push_back(mk(1,0,32'hE,0,MASK_HALF,0,0, 1,0,1,32'hFFFF_CAFE));
    vecs.push_back(mk(1,0,32'hC,0,MASK_WORD,0,0, 1,0,1,32'hCAFE_F00D));
    vecs.push_back(mk(1,0,32'h0,0,2'd3,0,0,      0,1,0,32'h0));
    vecs.push_back(mk(1,1,32'h0,0,MASK_WORD,0,0, 0,1,0,32'h0));
    vecs.push_back(mk(1,0,32'h2,0,MASK_WORD,0,0, 0,1,0,32'h0));
    vecs.push_back(mk(1,0,32'h1,0,MASK_HALF,0,0, 0,1,0,32'h0));
    vecs.push_back(mk(1,0,32'h4,0,MASK_WORD,0,1, 0,0,0,32'h0));
    vecs.push_back(mk(0,1,32'h3,32'hBEEF,MASK_HALF,0,0, 0,1,0,32'h0));
    vecs.push_back(mk(0,1,32'h8,32'h1234,2'd3,0,0,      0,1,0,32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b1, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
            vecs[i].mask, vecs[i].uns, vecs[i].fl);
      #1;
      chk($sformatf("vec%0d mem_en", i), mem_en, vecs[i].exp_en);
      chk($sformatf("vec%0d mem_we", i), mem_we, 0);
      chk($sformatf("vec%0d busy", i), busy, 0);
      next_cycle();
      idle();
      #1;
      chk($sformatf("vec%0d err", i), err, vecs[i].exp_err);
      chk($sformatf("vec%0d rdata_valid", i), rdata_valid, vecs[i].exp_rv);
      if (vecs[i].exp_rv) chk($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
      next_cycle();
      #1;
      chk($sformatf("vec%0d err drop", i), err, 0);
      next_cycle();
    end
    chk("ram0 untouched", ram[0], 32'hDEAD_BEEF);
    chk("ram2 untouched", ram[2], 32'h8000_7FFF);

    // ---------------- sb 0xAA to 0x5: read then merged write ----------------
    drive(1'b1, 1'b0, 1'b1, 32'h5, 32'h0000_00AA, MASK_BYTE, 1'b0, 1'b0);
    #1;
    chk("sb issue busy", busy, 1);
    chk("sb issue mem_en", mem_en, 1);
    chk("sb issue mem_we", mem_we, 0);
    chk("sb issue mem_addr", mem_addr, 1);
    next_cycle();
    idle();
    #1;
    chk("sb merge busy", busy, 1);
    chk("sb merge mem_we", mem_we, 1);
    chk("sb merge mem_addr", mem_addr, 1);
    chk("sb merge mem_wdata", mem_wdata, 32'h1122_AA44);
    chk("sb merge state", 32'(state_dbg), 32'(DMEM_RMW_MERGE));
    chk("sb merge err", err, 0);
    next_cycle();
    #1;
    chk("sb done busy", busy, 0);
    chk("sb done mem_en", mem_en, 0);
    chk("sb ram1", ram[1], 32'h1122_AA44);

    // ---------------- back-to-back word loads ----------------
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, MASK_WORD, 1'b0, 1'b0);
    #1;
    chk("b2b lw0 busy", busy, 0);
    chk("b2b lw0 mem_en", mem_en, 1);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, MASK_WORD, 1'b0, 1'b0);
    #1;
    chk("b2b lw4 busy", busy, 0);
    chk("b2b lw4 mem_addr", mem_addr, 1);
    chk("b2b rv0", rdata_valid, 1);
    chk("b2b rdata0", rdata, 32'hDEAD_BEEF);
    next_cycle();
    idle();
    #1;
    chk("b2b rv1", rdata_valid, 1);
    chk("b2b rdata1", rdata, 32'h1122_AA44);
    next_cycle();
    #1;
    chk("b2b rv drop", rdata_valid, 0);
    chk("b2b rdata hold", rdata, 32'h1122_AA44);

    // ---------------- flush during RMW_MERGE, held request accepted after ----------------
    drive(1'b1, 1'b0, 1'b1, 32'h4, 32'h0000_0077, MASK_BYTE, 1'b0, 1'b0);
    #1;
    chk("fl issue busy", busy, 1);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, MASK_WORD, 1'b0, 1'b1);
    #1;
    chk("fl merge busy", busy, 1);
    chk("fl merge mem_we", mem_we, 1);
    chk("fl merge mem_wdata", mem_wdata, 32'h1122_AA77);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, MASK_WORD, 1'b0, 1'b0);
    #1;
    chk("fl held busy", busy, 0);
    chk("fl held mem_en", mem_en, 1);
    chk("fl held mem_we", mem_we, 0);
    next_cycle();
    idle();
    #1;
    chk("fl held rv", rdata_valid, 1);
    chk("fl held rdata", rdata, 32'h1122_AA77);
    next_cycle();

    // ---------------- reset in RMW_MERGE abandons the write ----------------
    drive(1'b1, 1'b0, 1'b1, 32'h8, 32'h0000_0055, MASK_BYTE, 1'b0, 1'b0);
    #1;
    next_cycle();
    idle();
    #1;
    chk("rr merge mem_we", mem_we, 1);
    rst_n = 1'b0;
    #1;
    chk("rr mem_we", mem_we, 0);
    chk("rr mem_en", mem_en, 0);
    chk("rr busy", busy, 0);
    chk("rr rdata_valid", rdata_valid, 0);
    chk("rr err", err, 0);
    chk("rr rdata", rdata, 0);
    chk("rr mem_addr", mem_addr, 0);
    chk("rr mem_wdata", mem_wdata, 0);
    chk("rr state", 32'(state_dbg), 32'(DMEM_IDLE));
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    chk("rr ram2", ram[2], 32'h8000_7FFF);

    // ---------------- randomized run against the model ----------------
    for (int i = 0; i < 8; i++) begin
      exp_mem[i] = $urandom;
      poke(i, exp_mem[i]);
    end
    mg = 1'b0; p_err = 1'b0; p_rv = 1'b0; p_rdata = '0; last_rdata = '0;
    mg_addr = '0; mg_word = '0;

    for (int c = 0; c < 400; c++) begin
      r_v  = (c < 396) && ($urandom_range(0, 9) != 0);
      r_f  = ($urandom_range(0, 9) == 0);
      r_m  = 2'($urandom_range(0, 3));
      r_u  = 1'($urandom_range(0, 1));
      r_a  = $urandom_range(0, 31);
      r_wd = $urandom;
      case ($urandom_range(0, 6))
        0, 1, 2: begin r_rd = 1'b1; r_wr = 1'b0; end
        3, 4, 5: begin r_rd = 1'b0; r_wr = 1'b1; end
        default: begin r_rd = 1'b1; r_wr = 1'b1; end
      endcase
      drive(r_v, r_rd, r_wr, r_a, r_wd, r_m, r_u, r_f);
      #1;
      chk($sformatf("rnd%0d err", c), err, p_err);
      chk($sformatf("rnd%0d rdata_valid", c), rdata_valid, p_rv);
      chk($sformatf("rnd%0d rdata", c), rdata, p_rv ? p_rdata : last_rdata);

      e_busy = 1'b0; e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
      n_err = 1'b0; n_rv = 1'b0; n_rdata = '0;
      w = {{(AW-3){1'b0}}, r_a[4:2]};
      if (mg) begin
        e_busy = 1'b1; e_en = 1'b1; e_we = 1'b1; e_addr = mg_addr; e_wd = mg_word;
        mg = 1'b0;
      end else if (r_v && !r_f) begin
        if (is_illegal(r_rd, r_wr, r_a, r_m)) begin
          n_err = 1'b1;
        end else if (r_rd) begin
          e_en = 1'b1; e_addr = w; n_rv = 1'b1;
          n_rdata = model_load(exp_mem[r_a[4:2]], r_a[1:0], r_m, r_u);
        end else if (r_m == MASK_WORD) begin
          e_en = 1'b1; e_we = 1'b1; e_addr = w; e_wd = r_wd;
          exp_mem[r_a[4:2]] = r_wd;
        end else begin
          e_busy = 1'b1; e_en = 1'b1; e_addr = w;
          mg = 1'b1; mg_addr = w;
          mg_word = model_store(exp_mem[r_a[4:2]], r_a[1:0], r_m, r_wd);
          exp_mem[r_a[4:2]] = mg_word;
        end
      end
      chk($sformatf("rnd%0d busy", c), busy, e_busy);
      chk($sformatf("rnd%0d mem_en", c), mem_en, e_en);
      chk($sformatf("rnd%0d mem_we", c), mem_we, e_we);
      if (e_en) chk($sformatf("rnd%0d mem_addr", c), mem_addr, e_addr);
      if (e_we) chk($sformatf("rnd%0d mem_wdata", c), mem_wdata, e_wd);
      if (p_rv) last_rdata = p_rdata;
      p_err = n_err; p_rv = n_rv; p_rdata = n_rdata;
      next_cycle();
    end
    for (int i = 0; i < 8; i++) chk($sformatf("final ram%0d", i), ram[i], exp_mem[i]);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_rmw_port.md
Name: dmem_rmw_port

Overview:
- Data-memory access port at the MEM stage of the 5-stage RV32 pipeline.
- Sits between the EX/MEM register and a word-only, 1-cycle-latency synchronous data RAM.
- Word loads/stores are single-access. Byte/half loads are extracted and extended from the word.
- Byte/half stores run as a two-cycle read-modify-write. The block raises busy, which the hazard unit consumes as its sub-word-store stall condition.

Parameters:
- AW, 12, word-address width of the data RAM (RAM depth is 2^AW words).
- ERR_ON_MISALIGN, 1: if 1, misaligned or illegal requests raise err and make no RAM access. If 0, the offending low address bits are ignored and the access proceeds.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  MEM-stage request present this cycle
- req_read  input  1  load request
- req_write  input  1  store request
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- req_maskMode  input  2  0=byte, 1=half, 2=word, 3=illegal
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- flush  input  1  kill the request presented this cycle
- busy  output  1  port occupied next cycle; requester must hold its request
- rdata_valid  output  1  load data valid this cycle
- rdata  output  32  extended load data
- err  output  1  one-cycle pulse for an illegal, misaligned or read+write request
- mem_en  output  1  RAM enable
- mem_we  output  1  RAM write enable, full word
- mem_addr  output  AW  RAM word address, equal to req_addr[AW+1:2]
- mem_wdata  output  32  RAM write word
- mem_rdata  input  32  RAM read word, valid the cycle after a read is issued

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, rdata_valid, err, mem_en and mem_we are 0; rdata, mem_addr and mem_wdata are 0; internal registers are cleared.
- A request is accepted when req_valid=1, flush=0 and state=IDLE.
- Illegal requests:
  - maskMode=3.
  - read and write both set.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - Response when ERR_ON_MISALIGN=1: err=1 for the next cycle, no RAM access, no state change.
- Word store: mem_en=1, mem_we=1, mem_wdata=req_wdata in the same cycle. busy=0.
- Load:
  - Issue mem_en=1, mem_we=0 in the same cycle; register the lane (addr[1:0]), size and unsigned flag.
  - The next cycle drives rdata_valid=1 and rdata = extended mem_rdata.
  - Loads are pipelined: a new request may be accepted in the response cycle.
- Load extension:
  - byte: mem_rdata[8*lane+7 : 8*lane].
  - half: mem_rdata[16*addr[1]+15 : 16*addr[1]].
  - The selected field is sign- or zero-extended to 32 bits per the unsigned flag.
  - word: passed through unchanged.
- Sub-word store, FSM IDLE -> RMW_MERGE -> IDLE:
  - IDLE cycle:
    - issue a read (mem_en=1, mem_we=0).
    - latch word address, lane, size and wdata.
    - busy=1 combinationally.
  - RMW_MERGE cycle:
    - merged = mem_rdata with a byte lane replaced by wdata[7:0], or a half lane replaced by wdata[15:0].
    - drive mem_en=1, mem_we=1, mem_wdata=merged.
    - busy=1.
    - no new request is accepted.
    - return to IDLE.
- busy: (IDLE and accepted sub-word store) or state=RMW_MERGE. Otherwise 0.
- flush:
  - Affects only the request presented in the same cycle.
  - An RMW already in RMW_MERGE always completes its write (atomic).
  - An already-issued load still returns rdata_valid.
- rst_n asserted mid-RMW: the write is abandoned, the RAM word is unchanged, and the block returns to IDLE.
- rdata holds its last value when rdata_valid=0.

Decomposition:
- Shared package (pipeline_pkg):
  - MASK_BYTE=2'd0, MASK_HALF=2'd1, MASK_WORD=2'd2.
  - dmem FSM state encoding (IDLE, RMW_MERGE).
  - The hazard unit reuses the same mask constants.
- One combinational sub-module, dmem_lane_unit, performs lane merge for stores and lane extract/extend for loads. The parent holds the FSM and registers.

Test Plan:
- RAM[1]=0x11223344; sb 0xAA to 0x5 -> busy=1 for 2 cycles, read then write of RAM[1]=0x1122AA44, err=0.
- RAM[2]=0x8000_7FFF; lh 0xA signed -> next cycle rdata=0xFFFF8000, rdata_valid=1. lhu 0xA -> rdata=0x00008000.
- Back-to-back lw 0x0, lw 0x4 on consecutive cycles -> two consecutive rdata_valid cycles with the correct words, busy=0 throughout.
- sh to 0x3 with ERR_ON_MISALIGN=1 -> err pulse next cycle, mem_en=0, RAM unchanged.
- sb to 0x4 followed by flush=1 during RMW_MERGE -> the write still completes and busy drops after 2 cycles. A new request held during busy is accepted the cycle after.
- Start sb, then assert rst_n=0 in RMW_MERGE -> mem_we=0 immediately, the RAM word is unchanged, and all outputs return to their reset values.
